// File: rtl/frame_stream_driver.sv
// Streams a host-loaded WIDTH x HEIGHT frame into resize_filter and captures its output as a counted pixel stream.
// Optional macro FRAME_CHECKSUM_EN adds a 32-bit wrapping checksum of every captured pixel.
module frame_stream_driver #(
  parameter int WIDTH  = 410,
  parameter int HEIGHT = 361,
  parameter int FACTOR = 3,
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              scale_sel,
  output logic [7:0]        image_input,
  output logic              enable,
  output logic              enable_process,
  output logic              scale,
  input  logic [7:0]        image_output,
  output logic              pix_valid,
  output logic [7:0]        pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              done
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int N_IN     = WIDTH * HEIGHT;
  localparam int N_OUT_DN = ((WIDTH + 1) / FACTOR) * ((HEIGHT + 2) / FACTOR);
  localparam int N_OUT_UP = (WIDTH * FACTOR) * (HEIGHT * FACTOR);
  localparam logic [CNT_W-1:0]  LAST_DN = CNT_W'(N_OUT_DN - 1);
  localparam logic [CNT_W-1:0]  LAST_UP = CNT_W'(N_OUT_UP - 1);
  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W + 1)'(N_IN);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_mem [0:(2**ADDR_W)-1];
  logic [7:0]        r_ramQ;
  logic [ADDR_W:0]   r_rdAddr;
  logic              r_issueV;
  logic              r_enable;
  logic [7:0]        r_imageInput;
  logic              r_scale;
  logic [CNT_W-1:0]  r_outCnt;
  logic              w_startAccept;
  logic              w_issue;
  logic              w_lastPix;

  assign w_startAccept = (r_state == IDLE) && start;
  assign w_issue       = (r_state == LOAD) && (r_rdAddr != RD_END);
  assign w_lastPix     = (r_state == DRAIN) && (r_outCnt == (r_scale ? LAST_UP : LAST_DN));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // LOAD ends once the last read has left the two-stage RAM/output pipeline.
  always_comb begin
    w_nextState    = r_state;
    enable_process = 1'b0;
    pix_valid      = 1'b0;
    pix_data       = 8'd0;
    pix_last       = 1'b0;
    busy           = (r_state != IDLE);
    done           = 1'b0;
    case (r_state)
      IDLE:  if (start) w_nextState = LOAD;
      LOAD:  if (r_enable && !r_issueV) w_nextState = DRAIN;
      DRAIN: begin
        enable_process = 1'b1;
        pix_valid      = 1'b1;
        pix_data       = image_output;
        pix_last       = w_lastPix;
        if (w_lastPix) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Host writes land only while idle; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && (r_state == IDLE)) r_mem[wr_addr] <= wr_data;
    r_ramQ <= r_mem[r_rdAddr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdAddr     <= '0;
      r_issueV     <= 1'b0;
      r_enable     <= 1'b0;
      r_imageInput <= 8'd0;
      r_scale      <= 1'b0;
      r_outCnt     <= '0;
    end else begin
      r_issueV     <= w_issue;
      r_enable     <= r_issueV;
      r_imageInput <= r_issueV ? r_ramQ : 8'd0;
      if (w_startAccept) begin
        r_scale  <= scale_sel;
        r_rdAddr <= '0;
        r_outCnt <= '0;
      end else begin
        if (w_issue) r_rdAddr <= r_rdAddr + 1'b1;
        if (r_state == DRAIN) r_outCnt <= r_outCnt + 1'b1;
      end
    end
  end

  assign image_input = r_imageInput;
  assign enable      = r_enable;
  assign scale       = r_scale;

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst || w_startAccept) r_checksum <= 32'd0;
    else if (pix_valid)       r_checksum <= r_checksum + {24'd0, pix_data};
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_frame_stream_driver.sv
// Self-checking bench for frame_stream_driver on a small 10x7 frame with FACTOR 3.
// Scoreboard queues hold expected filter-input and captured-output pixels per frame.
module tb_frame_stream_driver;

  localparam int W      = 10;
  localparam int H      = 7;
  localparam int AW     = 7;
  localparam int N_IN   = W * H;
  localparam int N_DN   = 9;
  localparam int N_UP   = 630;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          scale_sel;
  logic [7:0]    image_input;
  logic          enable;
  logic          enable_process;
  logic          scale;
  logic [7:0]    image_output;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic          busy;
  logic          done;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]   checksum;
  logic [31:0]   expSum;
`endif

  frame_stream_driver #(
    .WIDTH(W), .HEIGHT(H), .FACTOR(3), .ADDR_W(AW), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .scale_sel(scale_sel), .image_input(image_input),
    .enable(enable), .enable_process(enable_process), .scale(scale),
    .image_output(image_output), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .done(done)
`ifdef FRAME_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct {
    bit       scaleSel;
    int       nOut;
    bit       wrWithStart;
    int       wAddr;
    bit [7:0] wData;
  } vector_t;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] ramModel [0:(2**AW)-1];
  int         inQ[$];
  int         outQ[$];
  int         filtCnt = 0;

  int cycleIdx = 0, e0 = 0, expScale = 0;
  int enCount, enRises, firstEnCycle, lastEnCycle, epOverlap;
  int firstEpCycle, lastEpCycle, validCount, validRises, firstValidCycle;
  int lastCount, lastAtIdx, lastCycle, doneCount, doneCycle, busyFallCycle, scaleBad;
  bit prevEn = 0, prevValid = 0, prevBusy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Stand-in for resize_filter: emits a running count while processing.
  always @(posedge clk) begin
    #1;
    if (enable_process) begin
      image_output = filtCnt[7:0];
      filtCnt++;
    end else begin
      image_output = 8'd0;
      filtCnt = 0;
    end
  end

  // Monitor samples on the falling edge and drains the scoreboard queues.
  always @(negedge clk) begin
    cycleIdx++;
    if (enable) begin
      if (!prevEn) enRises++;
      if (firstEnCycle < 0) firstEnCycle = cycleIdx;
      lastEnCycle = cycleIdx;
      enCount++;
      if (enable_process) epOverlap++;
      if (inQ.size() > 0) checkOutput("image_input", image_input, inQ.pop_front());
      else checkOutput("unexpected enable", 1, 0);
    end
    if (enable_process) begin
      if (firstEpCycle < 0) firstEpCycle = cycleIdx;
      lastEpCycle = cycleIdx;
    end
    if (pix_valid) begin
      if (!prevValid) validRises++;
      if (firstValidCycle < 0) firstValidCycle = cycleIdx;
      validCount++;
      if (outQ.size() > 0) checkOutput("pix_data", pix_data, outQ.pop_front());
      else checkOutput("unexpected pix_valid", 1, 0);
    end
    if (pix_last) begin
      lastCount++;
      lastAtIdx = validCount;
      lastCycle = cycleIdx;
    end
    if (done) begin
      doneCount++;
      doneCycle = cycleIdx;
    end
    if (prevBusy && !busy && busyFallCycle < 0) busyFallCycle = cycleIdx;
    if (busy && (int'(scale) != expScale)) scaleBad++;
    prevEn    = enable;
    prevValid = pix_valid;
    prevBusy  = busy;
  end

  task automatic clearStats();
    enCount = 0; enRises = 0; firstEnCycle = -1; lastEnCycle = -1; epOverlap = 0;
    firstEpCycle = -1; lastEpCycle = -1; validCount = 0; validRises = 0;
    firstValidCycle = -1; lastCount = 0; lastAtIdx = -1; lastCycle = -1;
    doneCount = 0; doneCycle = -1; busyFallCycle = -1; scaleBad = 0;
    inQ.delete();
    outQ.delete();
  endtask

  // Drives one accepted start (optionally with a same-cycle write) and fills the scoreboard.
  task automatic applyStimulus(input bit s, input int nOut, input bit wr, input int wA, input bit [7:0] wD);
    @(negedge clk); #1;
    clearStats();
    if (wr) ramModel[wA] = wD;
    for (int a = 0; a < N_IN; a++) inQ.push_back(int'(ramModel[a]));
`ifdef FRAME_CHECKSUM_EN
    expSum = 32'd0;
`endif
    for (int i = 0; i < nOut; i++) begin
      outQ.push_back(i % 256);
`ifdef FRAME_CHECKSUM_EN
      expSum = expSum + 32'(i % 256);
`endif
    end
    expScale  = int'(s);
    start     = 1'b1;
    scale_sel = s;
    wr_en     = wr;
    wr_addr   = AW'(wA);
    wr_data   = wD;
    e0        = cycleIdx + 1;
    @(negedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (doneCount == 0) checkOutput("done timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic checkFrame(input int nOut, input int sExp);
    checkOutput("first pixel cycle", firstEnCycle, e0 + 2);
    checkOutput("enable count", enCount, N_IN);
    checkOutput("enable runs", enRises, 1);
    checkOutput("enable/process overlap", epOverlap, 0);
    checkOutput("process follows enable", firstEpCycle, lastEnCycle + 1);
    checkOutput("valid starts with process", firstValidCycle, firstEpCycle);
    checkOutput("pix_valid count", validCount, nOut);
    checkOutput("pix_valid runs", validRises, 1);
    checkOutput("pix_last count", lastCount, 1);
    checkOutput("pix_last index", lastAtIdx, nOut);
    checkOutput("process ends at last", lastEpCycle, lastCycle);
    checkOutput("done after last", doneCycle, lastCycle + 1);
    checkOutput("done pulses", doneCount, 1);
    checkOutput("busy drop after done", busyFallCycle, doneCycle + 1);
    checkOutput("scale while busy", scaleBad, 0);
    checkOutput("scale held", scale, sExp);
    checkOutput("input queue left", inQ.size(), 0);
    checkOutput("output queue left", outQ.size(), 0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput("checksum", checksum, expSum);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst image_input", image_input, 0);
    checkOutput("rst enable", enable, 0);
    checkOutput("rst enable_process", enable_process, 0);
    checkOutput("rst scale", scale, 0);
    checkOutput("rst pix_valid", pix_valid, 0);
    checkOutput("rst pix_data", pix_data, 0);
    checkOutput("rst pix_last", pix_last, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
`ifdef FRAME_CHECKSUM_EN
    checkOutput("rst checksum", checksum, 0);
`endif
  endtask

  vector_t vectors [3];

  initial begin
    vectors[0] = '{scaleSel: 1'b0, nOut: N_DN, wrWithStart: 1'b1, wAddr: N_IN - 1, wData: 8'hC3};
    vectors[1] = '{scaleSel: 1'b1, nOut: N_UP, wrWithStart: 1'b0, wAddr: 0,        wData: 8'h00};
    vectors[2] = '{scaleSel: 1'b0, nOut: N_DN, wrWithStart: 1'b1, wAddr: 3,        wData: 8'h5A};

    rst = 1'b1; start = 1'b1; scale_sel = 1'b1; wr_en = 1'b0;
    wr_addr = '0; wr_data = 8'd0; image_output = 8'd0;
    clearStats();
    repeat (5) @(negedge clk);
    #1;
    checkResetOutputs();
    checkOutput("enable during reset", enCount, 0);
    rst = 1'b0; start = 1'b0; scale_sel = 1'b0;

    $display("[TB] loading frame RAM");
    for (int a = 0; a < N_IN - 1; a++) begin
      @(negedge clk); #1;
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(a % 256);
      ramModel[a] = 8'(a % 256);
    end
    @(negedge clk); #1;
    wr_en = 1'b0;

    for (int v = 0; v < 3; v++) begin
      $display("[TB] vector %0d scale_sel=%0d", v, vectors[v].scaleSel);
      applyStimulus(vectors[v].scaleSel, vectors[v].nOut, vectors[v].wrWithStart,
                    vectors[v].wAddr, vectors[v].wData);
      waitDone(N_IN + vectors[v].nOut + 20);
      checkFrame(vectors[v].nOut, int'(vectors[v].scaleSel));
    end

    $display("[TB] busy protection");
    applyStimulus(1'b0, N_DN, 1'b0, 0, 8'd0);
    repeat (5) @(negedge clk);
    #1;
    start = 1'b1; scale_sel = 1'b1; wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA;
    @(negedge clk); #1;
    start = 1'b0; scale_sel = 1'b0; wr_en = 1'b0;
    waitDone(N_IN + N_DN + 20);
    checkFrame(N_DN, 0);
    applyStimulus(1'b0, N_DN, 1'b0, 0, 8'd0);
    waitDone(N_IN + N_DN + 20);
    checkFrame(N_DN, 0);

    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, N_UP, 1'b0, 0, 8'd0);
    begin
      int n = 0;
      while (validCount < 101 && n < N_IN + N_UP + 20) begin
        @(negedge clk); #1;
        n++;
      end
    end
    checkOutput("reached pixel 100", validCount, 101);
    rst = 1'b1;
    @(negedge clk); #1;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("no done after reset", doneCount, 0);
    applyStimulus(1'b1, N_UP, 1'b0, 0, 8'd0);
    waitDone(N_IN + N_UP + 20);
    checkFrame(N_UP, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/frame_stream_driver.md
# frame_stream_driver

Drives one full image frame into `resize_filter` and captures its resized output stream, so hardware can run a resize without a testbench. Holds a WIDTH×HEIGHT 8-bit frame in internal RAM, loaded by a host write port. On `start` it streams the frame one pixel per clock with `enable`, then switches the filter to processing with `enable_process`. It then forwards the filter's `image_output` as a counted, valid-qualified pixel stream with a last marker.

## Interface
- `WIDTH`, 410, input frame width in pixels
- `HEIGHT`, 361, input frame height in pixels
- `FACTOR`, 3, resize factor; must match the filter's FILTER_SIZE
- `ADDR_W`, 18, frame RAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- `CNT_W`, 22, output pixel counter width; must hold the scale-up count

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `wr_en`  in  1  host frame RAM write strobe
- `wr_addr`  in  ADDR_W  host write address, raster order
- `wr_data`  in  8  host write pixel
- `start`  in  1  start-frame request, sampled in IDLE only
- `scale_sel`  in  1  1 = scale up, 0 = scale down; latched on accepted `start`
- `image_input`  out  8  pixel to filter
- `enable`  out  1  filter load strobe
- `enable_process`  out  1  filter process strobe
- `scale`  out  1  latched `scale_sel`, to filter
- `image_output`  in  8  filter output pixel
- `pix_valid`  out  1  `pix_data` valid
- `pix_data`  out  8  captured output pixel
- `pix_last`  out  1  marks the final output pixel
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE
  - LOAD: streams the frame into the filter.
  - DRAIN: captures output pixels.
  - DONE: emits `done`.
- IDLE → LOAD on `start`=1.
  - Latches `scale` ← `scale_sel`.
  - Clears the read address and output counter.
- LOAD issues RAM reads at addresses 0..N_IN−1, where N_IN = WIDTH*HEIGHT.
  - The RAM is synchronous, so data returns one cycle later.
  - `image_input`/`enable` are registered from the returned data.
- LOAD → DRAIN the cycle after the last pixel is presented.
  - `enable`=0 and `enable_process`=1 from that cycle on.
- Output count N_OUT:
  - Scale down: ((WIDTH+1)/FACTOR)*((HEIGHT+2)/FACTOR), integer division. Default 137*121 = 16577.
  - Scale up: (WIDTH*FACTOR)*(HEIGHT*FACTOR). Default 1230*1083 = 1332090.
- DRAIN, every cycle: `pix_valid`=1, `pix_data`=`image_output`, counter increments.
  - `pix_last`=1 when counter = N_OUT−1.
  - DRAIN → DONE after that cycle.
- DONE: `done`=1 and `enable_process`=0 for one cycle, then → IDLE.
- Host writes (`wr_en`) are accepted only in IDLE and dropped while `busy`=1.
- `start` while `busy`=1 is ignored and not queued.
- Simultaneous `wr_en` and `start` in IDLE: the write is performed and the frame starts. The written pixel is visible to the stream.

## Timing
- Reset values: `image_input`=0, `enable`=0, `enable_process`=0, `scale`=0, `pix_valid`=0, `pix_data`=0, `pix_last`=0, `busy`=0, `done`=0, state IDLE. RAM contents are not reset.
- `start` accepted at edge E0. Pixel k appears with `enable`=1 during cycle E0+2+k, for k = 0..N_IN−1.
- `enable` is contiguous for exactly N_IN cycles.
- The first `enable_process`=1 cycle immediately follows the last `enable` cycle.
- `pix_valid` is high for exactly N_OUT consecutive cycles, starting with the first `enable_process` cycle.
- `done` asserts the cycle after `pix_last`; `busy` drops the cycle after `done`.
- `rst` mid-frame:
  - Next edge returns to IDLE with all outputs at their reset values.
  - No `done` pulse is emitted.
  - RAM contents are retained.

## Configuration
- `FRAME_CHECKSUM_EN` defined:
  - Adds output `checksum` [31:0], the wrapping sum of every `pix_data` with `pix_valid`=1 in the frame.
  - Cleared on accepted `start` and on `rst`; holds its final value from `done` until the next `start`.
- `FRAME_CHECKSUM_EN` not defined: no `checksum` port and no accumulator logic.

## Test plan
- Reset: assert `rst` with `start`=1 → all outputs 0; no `enable` is produced while `rst`=1.
- Load pattern: write RAM[a] = a mod 256, `start` with `scale_sel`=0.
  - `enable` is high for exactly 148010 cycles.
  - `image_input` sequence is 0,1,…,255,0,…
  - First pixel appears at E0+2.
- Scale down: drive `image_output` = counter mod 256 from a bench model.
  - 16577 `pix_valid` cycles; `pix_last` only on the 16577th.
  - `done` one cycle later; `scale`=0 throughout.
- Scale up: `scale_sel`=1 → `scale`=1, 1332090 `pix_valid` cycles, then `done`.
- Busy protection: during LOAD, assert `start` and `wr_en` (addr 5, data 0xAA).
  - No restart occurs.
  - A following frame still outputs the original RAM[5].
- Mid-frame reset: `rst` at DRAIN pixel 100.
  - Outputs are 0 next cycle; no `done`.
  - A new `start` replays the identical stream.
  - With `FRAME_CHECKSUM_EN`: for a constant 1 output, `checksum` = 16577 after scale down.
